// File: rtl/clk_div_counter_seg_pkg.sv
// Shared constants for the seconds-style display counter: segment codes,
// the tens-digit blank code and the digit limits.
package clk_div_counter_seg_pkg;

    // Active-low segment codes: bit 7 = dp (always off), bits 6:0 = g..a
    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_A     = 8'h88;
    localparam logic [7:0] SEG_B     = 8'h83;
    localparam logic [7:0] SEG_C     = 8'hC6;
    localparam logic [7:0] SEG_D     = 8'hA1;
    localparam logic [7:0] SEG_E     = 8'h86;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Digit code that the encoder renders as all segments off
    localparam logic [3:0] BLANK_CODE = 4'hF;

    // Highest legal ones / tens digit (counter runs 00..59)
    localparam logic [3:0] MAX_ONES = 4'd9;
    localparam logic [3:0] MAX_TENS = 4'd5;

endpackage

// File: rtl/clk_div_counter_seg_bcd_counter.sv
// Two-digit BCD counter 00..59 advanced by step, with a status LED that
// toggles per step and a display copy of the tens digit that blanks a
// leading zero.
module bcd_counter
    import clk_div_counter_seg_pkg::*;
(
    input  logic       clock_in,
    input  logic       reset,
    input  logic       step,
    output logic [3:0] counter1,
    output logic [3:0] counter10,
    output logic [3:0] seg_counter10,
    output logic       led
);

    logic [3:0] ones_nxt;
    logic [3:0] tens_nxt;

    // Next digit values; any out-of-range digit falls back to 0 so a
    // corrupted state heals on the following step
    always_comb begin
        ones_nxt = counter1 + 4'd1;
        tens_nxt = counter10;
        if (counter1 >= MAX_ONES) begin
            ones_nxt = 4'd0;
            if (counter1 == MAX_ONES)
                tens_nxt = (counter10 >= MAX_TENS) ? 4'd0 : (counter10 + 4'd1);
            else if (counter10 > MAX_TENS)
                tens_nxt = 4'd0;
        end else if (counter10 > MAX_TENS) begin
            tens_nxt = 4'd0;
        end
    end

    // Counter and LED registers, updated only on step
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            counter1  <= 4'd0;
            counter10 <= 4'd0;
            led       <= 1'b0;
        end else if (step) begin
            counter1  <= ones_nxt;
            counter10 <= tens_nxt;
            led       <= ~led;
        end
    end

    // Leading-zero blanking of the tens digit
    always_comb begin
        seg_counter10 = (counter10 == 4'd0) ? BLANK_CODE : counter10;
    end

endmodule

// File: rtl/clk_div_counter_seg_clock_divider.sv
// Programmable divider: clock_out is a square wave with half-period
// max(divide_by,1) cycles; step pulses in the cycle whose edge takes
// clock_out from 1 to 0, i.e. once per full divided period.
module clock_divider (
    input  logic        clock_in,
    input  logic        reset,
    input  logic [31:0] divide_by,
    output logic        clock_out,
    output logic        step
);

    logic [31:0] div_cnt;
    logic [31:0] limit;
    logic        wrap;

    // Terminal count; 0 and 1 both mean "toggle every cycle". Comparing with
    // >= lets a mid-period drop of divide_by wrap on the very next edge.
    always_comb begin
        limit = (divide_by <= 32'd1) ? 32'd0 : (divide_by - 32'd1);
        wrap  = (div_cnt >= limit);
        step  = wrap & clock_out;
    end

    // Half-period counter and output toggle
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            div_cnt   <= 32'd0;
            clock_out <= 1'b0;
        end else if (wrap) begin
            div_cnt   <= 32'd0;
            clock_out <= ~clock_out;
        end else begin
            div_cnt   <= div_cnt + 32'd1;
        end
    end

endmodule

// File: rtl/clk_div_counter_seg_seven_seg.sv
// Purely combinational hex-to-seven-segment encoder, active-low outputs.
// Code 4'hF is reserved as the blank code and lights nothing.
module seven_seg
    import clk_div_counter_seg_pkg::*;
(
    input  logic [3:0] digit,
    output logic [7:0] seg
);

    // Table lookup; every input code has a defined output
    always_comb begin
        seg = SEG_BLANK;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            4'd10:   seg = SEG_A;
            4'd11:   seg = SEG_B;
            4'd12:   seg = SEG_C;
            4'd13:   seg = SEG_D;
            4'd14:   seg = SEG_E;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/clk_div_counter_seg.sv
// Board-level seconds display: divider -> BCD counter -> two segment
// encoders. clock_out is only exported; nothing inside runs on it.
module clk_div_counter_seg
    import clk_div_counter_seg_pkg::*;
(
    input  logic        clock_in,
    input  logic        reset,
    input  logic [31:0] divide_by,
    output logic        clock_out,
    output logic [3:0]  counter1,
    output logic [3:0]  counter10,
    output logic [3:0]  seg_counter10,
    output logic [7:0]  hex_ones,
    output logic [7:0]  hex_tens,
    output logic        led
);

    logic step;

    clock_divider u_div (
        .clock_in  (clock_in),
        .reset     (reset),
        .divide_by (divide_by),
        .clock_out (clock_out),
        .step      (step)
    );

    bcd_counter u_cnt (
        .clock_in      (clock_in),
        .reset         (reset),
        .step          (step),
        .counter1      (counter1),
        .counter10     (counter10),
        .seg_counter10 (seg_counter10),
        .led           (led)
    );

    seven_seg u_seg_ones (
        .digit (counter1),
        .seg   (hex_ones)
    );

    seven_seg u_seg_tens (
        .digit (seg_counter10),
        .seg   (hex_tens)
    );

endmodule

// File: tb/tb_clk_div_counter_seg.sv
// Directed bench for clk_div_counter_seg with an expected-value scoreboard.
module tb_clk_div_counter_seg;

    logic        clock_in = 1'b0;
    logic        reset    = 1'b1;
    logic [31:0] divide_by = 32'd1;
    logic        clock_out;
    logic [3:0]  counter1, counter10, seg_counter10;
    logic [7:0]  hex_ones, hex_tens;
    logic        led;

    logic [3:0]  ss_in = 4'd0;
    logic [7:0]  ss_out;

    int          n_vec = 0;
    int          n_err = 0;
    string       tag_q[$];
    logic [31:0] exp_q[$];

    logic [7:0]  seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92,
                                  8'h82, 8'hF8, 8'h80, 8'h90, 8'h88, 8'h83,
                                  8'hC6, 8'hA1, 8'h86, 8'hFF};

    clk_div_counter_seg dut (
        .clock_in      (clock_in),
        .reset         (reset),
        .divide_by     (divide_by),
        .clock_out     (clock_out),
        .counter1      (counter1),
        .counter10     (counter10),
        .seg_counter10 (seg_counter10),
        .hex_ones      (hex_ones),
        .hex_tens      (hex_tens),
        .led           (led)
    );

    seven_seg u_ss (
        .digit (ss_in),
        .seg   (ss_out)
    );

    always #5 clock_in = ~clock_in;

    task automatic push(input string tag, input logic [31:0] exp);
        tag_q.push_back(tag);
        exp_q.push_back(exp);
    endtask

    task automatic pop_chk(input logic [31:0] obs);
        string       tag;
        logic [31:0] exp;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL scoreboard_empty observed=%h", obs);
        end else begin
            tag = tag_q.pop_front();
            exp = exp_q.pop_front();
            assert (obs === exp) else begin
                n_err++;
                $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
            end
        end
    endtask

    // Advance one rising edge, sample 1 time unit later
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock_in);
            #1;
        end
    endtask

    // Reset held across an edge, released between edges
    task automatic do_reset(input logic [31:0] div);
        reset     = 1'b1;
        divide_by = div;
        @(negedge clock_in);
        @(negedge clock_in);
        reset = 1'b0;
    endtask

    initial begin
        // Reset state
        do_reset(32'd3);
        push("rst_clock_out", 32'd0);  pop_chk({31'd0, clock_out});
        push("rst_counter1", 32'd0);   pop_chk({28'd0, counter1});
        push("rst_counter10", 32'd0);  pop_chk({28'd0, counter10});
        push("rst_seg10", 32'hF);      pop_chk({28'd0, seg_counter10});
        push("rst_hex_ones", 32'hC0);  pop_chk({24'd0, hex_ones});
        push("rst_hex_tens", 32'hFF);  pop_chk({24'd0, hex_tens});
        push("rst_led", 32'd0);        pop_chk({31'd0, led});

        // divide_by=3: rise at edge 3, fall + count at edge 6
        push("d3_e2_clock_out", 32'd0);
        tick(2);  pop_chk({31'd0, clock_out});
        push("d3_e3_clock_out", 32'd1);
        tick(1);  pop_chk({31'd0, clock_out});
        push("d3_e5_counter1", 32'd0);
        tick(2);  pop_chk({28'd0, counter1});
        push("d3_e6_clock_out", 32'd0);
        push("d3_e6_counter1", 32'd1);
        push("d3_e6_led", 32'd1);
        push("d3_e6_hex_ones", 32'hF9);
        push("d3_e6_hex_tens", 32'hFF);
        tick(1);
        pop_chk({31'd0, clock_out});
        pop_chk({28'd0, counter1});
        pop_chk({31'd0, led});
        pop_chk({24'd0, hex_ones});
        pop_chk({24'd0, hex_tens});

        // divide_by=0 behaves as 1
        do_reset(32'd0);
        push("d0_e1_clock_out", 32'd1);
        tick(1);  pop_chk({31'd0, clock_out});
        push("d0_e2_counter1", 32'd1);
        tick(1);  pop_chk({28'd0, counter1});

        // divide_by=1, 20 cycles -> 10 steps
        do_reset(32'd1);
        push("d1_20_counter1", 32'd0);
        push("d1_20_counter10", 32'd1);
        push("d1_20_seg10", 32'd1);
        push("d1_20_hex_tens", 32'hF9);
        push("d1_20_hex_ones", 32'hC0);
        push("d1_20_led", 32'd0);
        tick(20);
        pop_chk({28'd0, counter1});
        pop_chk({28'd0, counter10});
        pop_chk({28'd0, seg_counter10});
        pop_chk({24'd0, hex_tens});
        pop_chk({24'd0, hex_ones});
        pop_chk({31'd0, led});

        // Continue to 59 (118 cycles) then wrap at 120
        push("d1_118_counter1", 32'd9);
        push("d1_118_counter10", 32'd5);
        push("d1_118_hex_tens", 32'h92);
        tick(98);
        pop_chk({28'd0, counter1});
        pop_chk({28'd0, counter10});
        pop_chk({24'd0, hex_tens});
        push("d1_120_counter1", 32'd0);
        push("d1_120_counter10", 32'd0);
        push("d1_120_hex_tens", 32'hFF);
        push("d1_120_led", 32'd0);
        tick(2);
        pop_chk({28'd0, counter1});
        pop_chk({28'd0, counter10});
        pop_chk({24'd0, hex_tens});
        pop_chk({31'd0, led});

        // Hold at 37, then async reset between edges
        do_reset(32'd1);
        push("c37_counter1", 32'd7);
        push("c37_counter10", 32'd3);
        push("c37_hex_ones", 32'hF8);
        push("c37_hex_tens", 32'hB0);
        push("c37_led", 32'd1);
        tick(74);
        pop_chk({28'd0, counter1});
        pop_chk({28'd0, counter10});
        pop_chk({24'd0, hex_ones});
        pop_chk({24'd0, hex_tens});
        pop_chk({31'd0, led});
        #2 reset = 1'b1;
        #1;
        push("arst_counter1", 32'd0);   pop_chk({28'd0, counter1});
        push("arst_counter10", 32'd0);  pop_chk({28'd0, counter10});
        push("arst_clock_out", 32'd0);  pop_chk({31'd0, clock_out});
        push("arst_led", 32'd0);        pop_chk({31'd0, led});
        push("arst_hex_ones", 32'hC0);  pop_chk({24'd0, hex_ones});
        push("arst_hex_tens", 32'hFF);  pop_chk({24'd0, hex_tens});

        // Full latency again after reset: divide_by=2 counts at edge 4
        do_reset(32'd2);
        push("rr_e3_counter1", 32'd0);
        tick(3);  pop_chk({28'd0, counter1});
        push("rr_e4_counter1", 32'd1);
        tick(1);  pop_chk({28'd0, counter1});

        // divide_by=5 at div_cnt=3, switch to 2: wrap on next edge
        do_reset(32'd5);
        tick(3);
        divide_by = 32'd2;
        push("sw_e4_clock_out", 32'd1);
        tick(1);  pop_chk({31'd0, clock_out});
        push("sw_e5_clock_out", 32'd1);
        tick(1);  pop_chk({31'd0, clock_out});
        push("sw_e6_clock_out", 32'd0);
        push("sw_e6_counter1", 32'd1);
        tick(1);
        pop_chk({31'd0, clock_out});
        pop_chk({28'd0, counter1});
        push("sw_e7_clock_out", 32'd0);
        tick(1);  pop_chk({31'd0, clock_out});
        push("sw_e8_clock_out", 32'd1);
        tick(1);  pop_chk({31'd0, clock_out});

        // Encoder sweep 0..15
        for (int d = 0; d < 16; d++) begin
            ss_in = d[3:0];
            push($sformatf("seg_%0d", d), {24'd0, seg_tab[d]});
            #1;
            pop_chk({24'd0, ss_out});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
